mesh_xy_router: RTL and testbench

//  Synchronous, buffered single-flit router node for a parametrised MAX_X x MAX_Y mesh.

---
 rtl/router_pkg.sv | 24 ++
 rtl/router_fifo.sv | 38 +++
 rtl/mesh_xy_router.sv | 93 +++++++++
 tb/tb_mesh_xy_router.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/router_pkg.sv
// router_pkg: port ids, flit field extraction and XY dimension-order route for mesh_xy_router
package router_pkg;
  localparam int N_PORTS = 5;
  localparam int FLIT_MAX = 256;
  typedef enum logic [2:0] {P_LOCAL, P_EAST, P_WEST, P_NORTH, P_SOUTH} port_e;
  typedef logic [FLIT_MAX-1:0] flit_max_t;
  // Flits are zero-extended to FLIT_MAX so one helper serves every parameterisation
  function automatic int fld(flit_max_t f, int lsb, int w);
    return int'(f >> lsb) & ((1 << w) - 1);
  endfunction
  function automatic int flit_dst_x(flit_max_t f, int pw, int xw, int yw);
    return fld(f, pw + 2 + yw, xw);
  endfunction
  function automatic int flit_dst_y(flit_max_t f, int pw, int yw);
    return fld(f, pw + 2, yw);
  endfunction
  function automatic int flit_kind(flit_max_t f, int pw);
    return fld(f, pw, 2);
  endfunction
  function automatic port_e xy_route(int dst_x, int dst_y, int src_x, int src_y);
    return dst_x > src_x ? P_EAST : dst_x < src_x ? P_WEST :
           dst_y > src_y ? P_NORTH : dst_y < src_y ? P_SOUTH : P_LOCAL;
  endfunction
endpackage

// File: rtl/router_fifo.sv
// router_fifo: synchronous FIFO with combinational head, used per router input
module router_fifo #(
  parameter int W = 38,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic [W-1:0] din_i,
  output logic [W-1:0] head_o,
  output logic         full_o,
  output logic         empty_o
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem_q [DEPTH];
  logic [AW-1:0] wp_q, rp_q;
  logic [AW:0] cnt_q;
  logic do_push, do_pop;
  assign full_o = cnt_q == (AW+1)'(DEPTH);
  assign empty_o = cnt_q == '0;
  assign do_push = push_i && !full_o;
  assign do_pop = pop_i && !empty_o;
  assign head_o = mem_q[rp_q];
  always_ff @(posedge clk) begin
    if (rst) begin
      wp_q <= '0;
      rp_q <= '0;
      cnt_q <= '0;
    end else begin
      wp_q <= wp_q + AW'(do_push);
      rp_q <= rp_q + AW'(do_pop);
      cnt_q <= cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end
  always_ff @(posedge clk)
    if (do_push) mem_q[wp_q] <= din_i;
endmodule

// File: rtl/mesh_xy_router.sv
// mesh_xy_router: 5-port buffered XY mesh router node with per-output round-robin and registered outputs
module mesh_xy_router
  import router_pkg::*;
#(
  parameter int PAYLOAD = 32,
  parameter int X_W = 2,
  parameter int Y_W = 2,
  parameter int MAX_X = 4,
  parameter int MAX_Y = 4,
  parameter int SRC_X = 0,
  parameter int SRC_Y = 0,
  parameter int DEPTH = 4,
  parameter int W = X_W + Y_W + 2 + PAYLOAD
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_PORTS-1:0]   req_i,
  output logic [N_PORTS-1:0]   ack_i,
  input  logic [N_PORTS*W-1:0] data_i,
  output logic [N_PORTS-1:0]   req_o,
  input  logic [N_PORTS-1:0]   ack_o,
  output logic [N_PORTS*W-1:0] data_o,
  output logic [15:0]          drop_cnt
);
  logic [N_PORTS-1:0] full, empty, push, pop, drop;
  logic [W-1:0] head [N_PORTS];
  port_e rt [N_PORTS];
  int dx [N_PORTS], dy [N_PORTS];
  logic [N_PORTS-1:0][N_PORTS-1:0] gnt_m;
  logic [15:0] drop_q, drop_d;
  logic [2:0] ndrop;
  logic [16:0] dsum;
  assign ack_i = ~full & {N_PORTS{~rst}};
  assign push = req_i & ack_i;
  assign drop_cnt = drop_q;
  for (genvar p = 0; p < N_PORTS; p++) begin : g_in
    router_fifo #(.W(W), .DEPTH(DEPTH)) u_fifo (
      .clk(clk), .rst(rst), .push_i(push[p]), .pop_i(pop[p]),
      .din_i(data_i[p*W +: W]), .head_o(head[p]), .full_o(full[p]), .empty_o(empty[p])
    );
  end
  always_comb begin
    for (int p = 0; p < N_PORTS; p++) begin
      dx[p] = flit_dst_x(flit_max_t'(head[p]), PAYLOAD, X_W, Y_W);
      dy[p] = flit_dst_y(flit_max_t'(head[p]), PAYLOAD, Y_W);
      drop[p] = !empty[p] && (dx[p] >= MAX_X || dy[p] >= MAX_Y);
      rt[p] = xy_route(dx[p], dy[p], SRC_X, SRC_Y);
    end
  end
  // Out-of-range heads are discarded without arbitration; granted heads pop on load
  always_comb begin
    pop = drop;
    ndrop = '0;
    for (int p = 0; p < N_PORTS; p++) ndrop = ndrop + 3'(drop[p]);
    for (int o = 0; o < N_PORTS; o++) pop = pop | gnt_m[o];
    dsum = {1'b0, drop_q} + 17'(ndrop);
    drop_d = dsum[16] ? 16'hFFFF : dsum[15:0];
  end
  always_ff @(posedge clk) drop_q <= rst ? '0 : drop_d;
  for (genvar o = 0; o < N_PORTS; o++) begin : g_out
    logic [N_PORTS-1:0] cand;
    logic [2:0] rr_q, rr_d, gidx;
    logic any, ld, req_q;
    logic [W-1:0] data_q;
    // Descending scan so the candidate nearest rr_q is assigned last and wins
    always_comb begin
      for (int p = 0; p < N_PORTS; p++) cand[p] = !empty[p] && !drop[p] && rt[p] == port_e'(o);
      any = 1'b0;
      gidx = rr_q;
      for (int k = N_PORTS - 1; k >= 0; k--)
        if (cand[(int'(rr_q) + k) % N_PORTS]) begin
          any = 1'b1;
          gidx = 3'((int'(rr_q) + k) % N_PORTS);
        end
      ld = !req_q || ack_o[o];
      rr_d = ld && any ? (gidx == 3'(N_PORTS - 1) ? 3'd0 : gidx + 3'd1) : rr_q;
    end
    assign gnt_m[o] = ld && any ? {{(N_PORTS-1){1'b0}}, 1'b1} << gidx : '0;
    always_ff @(posedge clk) begin
      if (rst) begin
        req_q <= 1'b0;
        data_q <= '0;
        rr_q <= '0;
      end else begin
        req_q <= ld ? any : req_q;
        data_q <= ld && any ? head[gidx] : data_q;
        rr_q <= rr_d;
      end
    end
    assign req_o[o] = req_q;
    assign data_o[o*W +: W] = data_q;
  end
endmodule

// File: tb/tb_mesh_xy_router.sv
// tb_mesh_xy_router: directed checks of node (1,1) in a 4x4 mesh with 3-bit coordinate fields
module tb_mesh_xy_router;
  import router_pkg::*;
  localparam int XW = 3, YW = 3, PW = 32, W = XW + YW + 2 + PW;
  logic clk = 1'b0, rst = 1'b1;
  logic [4:0] req_i = '0, ack_i, req_o, ack_o = '0;
  logic [5*W-1:0] data_i = '0, data_o;
  logic [15:0] drop_cnt;
  int vecs = 0, errs = 0;
  logic [W-1:0] f, g, e;
  logic [W-1:0] fl [5];
  logic [W-1:0] expq [5][$];
  int seq [5];
  int exp_src, got_n, acc_n, first_c, last_c;

  mesh_xy_router #(.PAYLOAD(PW), .X_W(XW), .Y_W(YW), .MAX_X(4), .MAX_Y(4),
                   .SRC_X(1), .SRC_Y(1), .DEPTH(4)) dut (
    .clk(clk), .rst(rst), .req_i(req_i), .ack_i(ack_i), .data_i(data_i),
    .req_o(req_o), .ack_o(ack_o), .data_o(data_o), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [W-1:0] mk(input int dx, input int dy, input int k, input logic [31:0] p);
    return {3'(dx), 3'(dy), 2'(k), p};
  endfunction

  function automatic logic [W-1:0] dout(input int o);
    return data_o[o*W +: W];
  endfunction

  task automatic send(input int p, input logic [W-1:0] fv);
    int n = 0;
    while (!ack_i[p] && n < 20) begin
      cyc();
      n++;
    end
    chk("send_ack", 64'(ack_i[p]), 64'(1));
    if (ack_i[p]) begin
      req_i[p] = 1'b1;
      data_i[p*W +: W] = fv;
      cyc();
      req_i[p] = 1'b0;
    end
  endtask

  initial begin
    ack_o = '1;
    repeat (3) cyc();
    chk("rst_req_o", 64'(req_o), 64'(0));
    chk("rst_data_o", 64'(|data_o), 64'(0));
    chk("rst_ack_i", 64'(ack_i), 64'(0));
    chk("rst_drop", 64'(drop_cnt), 64'(0));
    rst = 1'b0;
    #1;
    chk("rst_ack_after", 64'(ack_i), 64'h1f);

    f = mk(3, 1, 0, 32'hA5);
    req_i[0] = 1'b1;
    data_i[0 +: W] = f;
    cyc();
    req_i[0] = 1'b0;
    chk("t1_not_yet", 64'(req_o), 64'(0));
    cyc();
    chk("t1_req_east", 64'(req_o), 64'b00010);
    chk("t1_data", 64'(dout(1)), 64'(f));
    cyc();
    chk("t1_idle", 64'(req_o), 64'(0));

    f = mk(1, 1, 1, 32'h1111);
    g = mk(1, 3, 2, 32'h2222);
    req_i[2] = 1'b1;
    data_i[2*W +: W] = f;
    cyc();
    req_i[2] = 1'b0;
    req_i[1] = 1'b1;
    data_i[1*W +: W] = g;
    cyc();
    req_i[1] = 1'b0;
    chk("t2_local_req", 64'(req_o), 64'b00001);
    chk("t2_local_data", 64'(dout(0)), 64'(f));
    cyc();
    chk("t2_north_req", 64'(req_o), 64'b01000);
    chk("t2_north_data", 64'(dout(3)), 64'(g));
    cyc();
    chk("t2_idle", 64'(req_o), 64'(0));

    rst = 1'b1;
    cyc();
    rst = 1'b0;
    #1;
    exp_src = 1;
    got_n = 0;
    acc_n = 0;
    first_c = -1;
    last_c = -1;
    for (int c = 0; c < 40; c++) begin
      if (req_o[0]) begin
        e = expq[exp_src].size() > 0 ? expq[exp_src].pop_front() : '0;
        chk("t3_rr_flit", 64'(dout(0)), 64'(e));
        got_n++;
        if (first_c < 0) first_c = c;
        last_c = c;
        exp_src = exp_src == 4 ? 1 : exp_src + 1;
      end
      for (int p = 1; p < 5; p++) begin
        req_i[p] = c < 12 && ack_i[p];
        if (req_i[p]) begin
          data_i[p*W +: W] = mk(1, 1, p, {8'(p), 24'(seq[p])});
          expq[p].push_back(mk(1, 1, p, {8'(p), 24'(seq[p])}));
          seq[p]++;
          acc_n++;
        end
      end
      cyc();
    end
    req_i = '0;
    chk("t3_count", 64'(got_n), 64'(acc_n));
    chk("t3_rate", 64'(last_c - first_c + 1), 64'(got_n));
    chk("t3_left", 64'(expq[1].size() + expq[2].size() + expq[3].size() + expq[4].size()), 64'(0));

    ack_o = 5'b11101;
    for (int i = 0; i < 5; i++) begin
      fl[i] = mk(3, 1, 0, 32'hB000 + i);
      send(0, fl[i]);
    end
    chk("t4_ack_low", 64'(ack_i[0]), 64'(0));
    for (int i = 0; i < 3; i++) begin
      chk("t4_hold_req", 64'(req_o[1]), 64'(1));
      chk("t4_hold_data", 64'(dout(1)), 64'(fl[0]));
      cyc();
    end
    ack_o = '1;
    for (int i = 0; i < 5; i++) begin
      chk("t4_out_req", 64'(req_o[1]), 64'(1));
      chk("t4_out_data", 64'(dout(1)), 64'(fl[i]));
      cyc();
    end
    chk("t4_drained", 64'(req_o), 64'(0));

    send(0, mk(5, 0, 0, 32'hDEAD));
    chk("t5_no_req_a", 64'(req_o), 64'(0));
    cyc();
    chk("t5_drop1", 64'(drop_cnt), 64'(1));
    chk("t5_no_req_b", 64'(req_o), 64'(0));
    data_i[0*W +: W] = mk(5, 0, 0, 32'h1);
    data_i[1*W +: W] = mk(1, 4, 1, 32'h2);
    data_i[2*W +: W] = mk(4, 4, 2, 32'h3);
    data_i[3*W +: W] = mk(7, 1, 3, 32'h4);
    data_i[4*W +: W] = mk(0, 7, 0, 32'h5);
    req_i = '1;
    cyc();
    req_i = '0;
    cyc();
    chk("t5_drop6", 64'(drop_cnt), 64'(6));
    req_i = '1;
    for (int n = 1; n <= 13200; n++) begin
      cyc();
      if (n == 100) chk("t5_flood", 64'(drop_cnt), 64'(501));
    end
    req_i = '0;
    cyc();
    cyc();
    chk("t5_sat", 64'(drop_cnt), 64'hFFFF);
    chk("t5_no_req_c", 64'(req_o), 64'(0));

    ack_o = 5'b11101;
    for (int i = 0; i < 4; i++) send(0, mk(3, 1, 0, 32'hC000 + i));
    chk("t6_pre_req", 64'(req_o), 64'b00010);
    rst = 1'b1;
    cyc();
    chk("t6_req", 64'(req_o), 64'(0));
    chk("t6_data", 64'(|data_o), 64'(0));
    chk("t6_drop", 64'(drop_cnt), 64'(0));
    chk("t6_ack_rst", 64'(ack_i), 64'(0));
    rst = 1'b0;
    #1;
    chk("t6_ack", 64'(ack_i), 64'h1f);
    ack_o = '1;
    repeat (3) cyc();
    chk("t6_quiet", 64'(req_o), 64'(0));
    f = mk(1, 0, 3, 32'h5050);
    g = mk(2, 1, 1, 32'h6060);
    req_i[2] = 1'b1;
    data_i[2*W +: W] = f;
    req_i[1] = 1'b1;
    data_i[1*W +: W] = g;
    cyc();
    req_i = '0;
    cyc();
    chk("t6_req_new", 64'(req_o), 64'b10010);
    chk("t6_south", 64'(dout(4)), 64'(f));
    chk("t6_uturn", 64'(dout(1)), 64'(g));

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
